read_back_regs: RTL and testbench
=================================

# read_back_regs

Register bank with a write-back port and a handshaked read-back port. Writes land in `DEPTH` enabled registers, updated on a single clock edge under synchronous reset. Reads are accepted through a valid/ready request channel and answered one cycle later on a valid/ready response channel. The block sits beside write-back sequential logic and is the path software or a checker uses to read stored state back.

## Interface
Parameters:
- `WIDTH`, 8, data width of each register.
- `DEPTH`, 4, number of registers; need not be a power of two.
- `RST_VAL`, 0, value loaded into every register on reset.

Ports (`AW = max(1, $clog2(DEPTH))`):
- `clk`  input  1  single clock; all state updates on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `wr_en`  input  1  write strobe.
- `wr_addr`  input  AW  write index.
- `wr_data`  input  WIDTH  write value.
- `rd_req_valid`  input  1  read request present.
- `rd_req_ready`  output  1  request accepted when both are high.
- `rd_addr`  input  AW  read index, sampled at acceptance.
- `rd_rsp_valid`  output  1  response present.
- `rd_rsp_ready`  input  1  consumer takes the response when both are high.
- `rd_rsp_data`  output  WIDTH  read value.
- `rd_rsp_err`  output  1  the accepted `rd_addr` was ≥ `DEPTH`.

## Operation
- Storage:
  - `wr_en` with `wr_addr < DEPTH` updates `mem[wr_addr]` at the edge.
  - An out-of-range write is dropped silently.
  - With `wr_en` low, the registers hold their value. No implicit writes occur.
- Read FSM, states `IDLE` and `RESP`:
  - `IDLE`: `rd_req_ready = 1`. An accepted request moves the FSM to `RESP` and loads the response registers.
  - `RESP`: `rd_rsp_valid = 1`, and `rd_req_ready = rd_rsp_ready`.
    - If the response is taken and a new request is accepted in the same cycle, stay in `RESP` and reload.
    - If the response is taken with no new request, go to `IDLE`.
    - If the response is not taken, hold.
- Response content:
  - `rd_rsp_data = mem[rd_addr]` as it stood before any write in the acceptance cycle. See Configuration for bypass.
  - An out-of-range read gives `rd_rsp_err = 1` and `rd_rsp_data = 0`.
- Stability: while `rd_rsp_valid && !rd_rsp_ready`, `rd_rsp_data` and `rd_rsp_err` hold. Later writes to the same register do not alter a held response.
- Reset values:
  - FSM goes to `IDLE`.
  - `rd_rsp_valid = 0`, `rd_rsp_data = 0`, `rd_rsp_err = 0`, `rd_req_ready = 1`.
  - All `mem` entries take `RST_VAL`.
- Reset mid-operation: a pending response is discarded, and `rd_rsp_valid` is low the cycle after `rst`. A request presented during `rst` is not accepted.

## Timing
- Write-to-storage latency: 1 edge.
- Read latency: response valid exactly 1 cycle after acceptance.
- Throughput: 1 read/cycle while `rd_rsp_ready` stays high.
- `rd_req_ready` is combinational from FSM state and `rd_rsp_ready` only. It never depends on `rd_req_valid`.
- All other outputs are registered.

## Configuration
- `READ_BACK_BYPASS_EN` defined: in the acceptance cycle, if `wr_en` is high and `wr_addr == rd_addr < DEPTH`, the response carries `wr_data` (write-first).
- Undefined: the response carries the old stored value (read-first).
- Storage behaviour is identical in both builds.

## Structure
- Package `read_back_pkg` holds:
  - `typedef enum logic {IDLE, RESP} rb_state_e`.
  - The `AW` computation helper function.
- Sub-module `read_back_store` holds the `DEPTH`×`WIDTH` register array and write decode. It exposes a combinational read of `mem[idx]`.
- The top level holds the FSM, response registers and bypass mux.

## Test plan
- Reset then idle read: `rst` for 2 cycles, then request `rd_addr=2`.
  - `rd_rsp_valid` goes high 1 cycle after acceptance.
  - `rd_rsp_data = RST_VAL`, `rd_rsp_err = 0`.
- Write then read: write `0xA5` to address 1, read address 1 on the next cycle.
  - `rd_rsp_data = 0xA5`.
- Same-cycle write/read to address 3: `mem[3] = 0x11`, write `0x22` while accepting a read of 3.
  - Response is `0x22` with `READ_BACK_BYPASS_EN`, `0x11` without it.
  - `mem[3]` reads `0x22` afterwards in both builds.
- Backpressure: hold `rd_rsp_ready = 0` for 3 cycles after a read of address 0 (value `0x5A`), and write `0xFF` to address 0 meanwhile.
  - `rd_rsp_data` stays `0x5A`.
  - `rd_req_ready = 0` throughout.
  - The response completes when ready rises.
- Back-to-back with DEPTH=5: keep `rd_rsp_ready = 1` and stream addresses 0, 4, 6.
  - Three responses arrive on consecutive cycles.
  - Address 6 gives `rd_rsp_err = 1`, data `0`.
  - Write to address 6 leaves all entries unchanged.
- Reset mid-response: assert `rst` while `rd_rsp_valid = 1` and `rd_rsp_ready = 0`.
  - Next cycle: `rd_rsp_valid = 0`, `rd_req_ready = 1`, storage back at `RST_VAL`.

Source files
------------

// File: rtl/read_back_pkg.sv
// Shared types and helpers for the read-back register bank.
package read_back_pkg;

  typedef enum logic {IDLE, RESP} rb_state_e;

  function automatic int aw_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/read_back_store.sv
// Register array with write decode and a combinational indexed read.
module read_back_store
  import read_back_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int AW = aw_f(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Per-entry decode: out-of-range indices match nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= RST_VAL;
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_addr == AW'(i))
          mem[i] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_idx == AW'(i))
        rd_data = mem[i];
  end

endmodule

// File: rtl/read_back_regs.sv
// Register bank with handshaked one-cycle read-back port.
// Optional write-first bypass: define READ_BACK_BYPASS_EN.
module read_back_regs
  import read_back_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int AW = aw_f(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req_valid,
  output logic             rd_req_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_rsp_valid,
  input  logic             rd_rsp_ready,
  output logic [WIDTH-1:0] rd_rsp_data,
  output logic             rd_rsp_err
);

  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  rb_state_e        state, state_n;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] rsp_d;
  logic             rd_in;
  logic             accept;

  read_back_store #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL),
    .AW      (AW)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_idx  (rd_addr),
    .rd_data (rd_q)
  );

  assign rd_in        = {1'b0, rd_addr} < LIM;
  assign rd_req_ready = (state == IDLE) || rd_rsp_ready;
  assign rd_rsp_valid = (state == RESP);
  assign accept       = rd_req_valid && rd_req_ready;

`ifdef READ_BACK_BYPASS_EN
  logic wr_hit;
  assign wr_hit = wr_en && (wr_addr == rd_addr);
  assign rsp_d  = !rd_in ? '0 : (wr_hit ? wr_data : rd_q);
`else
  assign rsp_d  = rd_in ? rd_q : '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = RESP;
      RESP: if (rd_rsp_ready && !rd_req_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Response registers only move on acceptance, so a stalled response holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_rsp_data <= '0;
      rd_rsp_err  <= 1'b0;
    end else if (accept) begin
      rd_rsp_data <= rsp_d;
      rd_rsp_err  <= !rd_in;
    end
  end

endmodule

// File: tb/tb_read_back_regs.sv
// Randomized and directed bench for read_back_regs against a transaction model.
module tb_read_back_regs;

  localparam int W = 8;
  localparam int D = 5;
  localparam int AW = 3;
  localparam logic [W-1:0] RV = 8'h3C;

  logic          clk = 0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_rsp_valid;
  logic          rd_rsp_ready;
  logic [W-1:0]  rd_rsp_data;
  logic          rd_rsp_err;

  always #5 clk = ~clk;

  read_back_regs #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (RV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_addr      (rd_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_err   (rd_rsp_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // model: stored values plus the one outstanding response
  logic [W-1:0] m_mem [D];
  logic         m_v;
  logic [W-1:0] m_d;
  logic         m_e;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input logic r, input logic v, input logic [AW-1:0] a,
                      input logic rr, input logic we,
                      input logic [AW-1:0] wa, input logic [W-1:0] wd);
    logic rdy;
    logic acc;
    logic hit;
    @(negedge clk);
    rst = r; rd_req_valid = v; rd_addr = a; rd_rsp_ready = rr;
    wr_en = we; wr_addr = wa; wr_data = wd;
    #1;
    rdy = !m_v || rr;
    chk("req_ready", 32'(rd_req_ready), 32'(rdy));
    if (r) begin
      m_v = 0; m_d = '0; m_e = 0;
      for (int i = 0; i < D; i++) m_mem[i] = RV;
    end else begin
      acc = v && rdy;
      if (acc) begin
        m_v = 1;
        m_e = (int'(a) >= D);
`ifdef READ_BACK_BYPASS_EN
        hit = we && (wa == a);
`else
        hit = 0;
`endif
        if (m_e) m_d = '0;
        else if (hit) m_d = wd;
        else m_d = m_mem[a];
      end else if (m_v && rr) begin
        m_v = 0;
      end
      if (we && int'(wa) < D) m_mem[wa] = wd;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(rd_rsp_valid), 32'(m_v));
    if (m_v || r) begin
      chk("rsp_data", 32'(rd_rsp_data), 32'(m_d));
      chk("rsp_err", 32'(rd_rsp_err), 32'(m_e));
    end
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(0, 1, a, 1, 0, 0, 0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    step(0, 0, 0, 1, 1, a, d);
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_req_valid = 0; rd_addr = 0; rd_rsp_ready = 0;
    m_v = 0; m_d = '0; m_e = 0;
    for (int i = 0; i < D; i++) m_mem[i] = RV;

    // reset, then read address 2
    step(1, 1, 2, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    rd(2);
    step(0, 0, 0, 1, 0, 0, 0);

    // write then read
    wr(1, 8'hA5);
    rd(1);

    // same-cycle write/read of address 3
    wr(3, 8'h11);
    step(0, 1, 3, 1, 1, 3, 8'h22);
    rd(3);

    // backpressure with a write to the held address
    wr(0, 8'h5A);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0, 8'hFF);
    step(0, 0, 0, 1, 0, 0, 0);
    rd(0);

    // streaming reads, including out-of-range, plus an out-of-range write
    step(0, 1, 0, 1, 1, 6, 8'h77);
    step(0, 1, 4, 1, 0, 0, 0);
    step(0, 1, 6, 1, 0, 0, 0);
    for (int i = 0; i < D; i++) rd(AW'(i));
    step(0, 0, 0, 1, 0, 0, 0);

    // reset while a response is stalled
    step(0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < D; i++) rd(AW'(i));

    // random traffic
    for (int n = 0; n < 600; n++)
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
           W'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
